// File: rtl/regfile_pkg.sv
// Shared constants and types for the register bank and its write-port scheduler.
package regfile_pkg;

    localparam int unsigned RF_ADDR_W   = 4;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 2 ** RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    // Width of a pointer that selects one of n requesters (at least 1 bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr_i (mod N).
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]              req_i,
    input  logic [ptr_width(N)-1:0]   ptr_i,
    output logic [N-1:0]              grant_o,
    output logic                      valid_o
);

    localparam int unsigned IW = ptr_width(N);

    logic [IW-1:0] idx;

    // Scan requesters starting at the pointer, wrapping, and grant the first one found.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(ptr_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler and pending-write scoreboard for the register bank.
// Requesters share one registered write port via round-robin arbitration;
// the scoreboard flags RAW hazards on the two read selects.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DATA_W = RF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic                     rf_en,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_din,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ready,
    input  logic [ADDR_W-1:0]        src1,
    input  logic [ADDR_W-1:0]        src2,
    output logic                     src1_busy,
    output logic                     src2_busy,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned PTR_W    = ptr_width(N_REQ);

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d, ptr_next;
    logic                rf_en_q, rf_en_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d, sel_addr;
    logic [DATA_W-1:0]   rf_din_q, rf_din_d, sel_data;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [N_REQ-1:0]    grant;
    logic                arb_valid;
    logic                xfer;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (arb_valid)
    );

    // No handshake or reservation may complete while reset is asserted.
    assign req_ready = rst ? '0 : grant;
    assign xfer      = arb_valid & ~rst;
    assign rsv_ready = ~rst & ~busy_q[rsv_addr];
    assign src1_busy = busy_q[src1];
    assign src2_busy = busy_q[src2];
    assign busy_vec  = busy_q;
    assign rf_en     = rf_en_q;
    assign rf_addr   = rf_addr_q;
    assign rf_din    = rf_din_q;

    // Mux the granted requester's slice and compute the pointer that follows it.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        ptr_next = rr_ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                ptr_next = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    // Next-state for write port, pointer and scoreboard; a same-edge set beats the clear.
    always_comb begin
        rr_ptr_d  = xfer ? ptr_next : rr_ptr_q;
        rf_en_d   = xfer;
        rf_addr_d = xfer ? sel_addr : rf_addr_q;
        rf_din_d  = xfer ? sel_data : rf_din_q;
        busy_d    = busy_q;
        if (rf_en_q) begin
            busy_d[rf_addr_q] = 1'b0;
        end
        if (rsv_valid && rsv_ready) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // State registers; reset drops any registered write and all reservations.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            rf_en_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_din_q  <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_en_q   <= rf_en_d;
            rf_addr_q <= rf_addr_d;
            rf_din_q  <= rf_din_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios, then
// protocol-legal random traffic, all compared against a behavioural model.
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [7:0]  req_addr;
    logic [63:0] req_data;
    logic        rf_en;
    logic [3:0]  rf_addr;
    logic [31:0] rf_din;
    logic        rsv_valid, rsv_ready;
    logic [3:0]  rsv_addr, src1, src2;
    logic        src1_busy, src2_busy;
    logic [15:0] busy_vec;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Behavioural model state
    bit          m_en;
    int          m_addr;
    logic [31:0] m_din;
    bit          m_busy [RF_NUM_REGS];
    int          m_ptr;
    logic [31:0] bank   [RF_NUM_REGS];
    int          last_g;
    bit          held   [2];

    regfile_wb_scheduler #(.N_REQ(2), .ADDR_W(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_en     (rf_en),
        .rf_addr   (rf_addr),
        .rf_din    (rf_din),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .src1      (src1),
        .src2      (src2),
        .src1_busy (src1_busy),
        .src2_busy (src2_busy),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare all outputs with the model, then advance the model at the edge.
    task automatic step();
        int          g;
        logic [1:0]  exp_rdy;
        logic [15:0] bv;
        bit          acc;
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                int i;
                i = (m_ptr + k) % 2;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
        for (int r = 0; r < RF_NUM_REGS; r++) bv[r] = m_busy[r];
        chk("req_ready", req_ready, exp_rdy);
        chk("rf_en",     rf_en,     m_en);
        chk("rf_addr",   rf_addr,   m_addr);
        chk("rf_din",    rf_din,    m_din);
        chk("busy_vec",  busy_vec,  bv);
        chk("src1_busy", src1_busy, m_busy[src1]);
        chk("src2_busy", src2_busy, m_busy[src2]);
        chk("rsv_ready", rsv_ready, !rst && !m_busy[rsv_addr]);
        acc = !rst && rsv_valid && !m_busy[rsv_addr];
        @(posedge clk);
        if (m_en) bank[m_addr] = m_din;
        if (rst) begin
            m_en = 0; m_addr = 0; m_din = '0; m_ptr = 0;
            for (int r = 0; r < RF_NUM_REGS; r++) m_busy[r] = 0;
        end else begin
            if (m_en) m_busy[m_addr] = 0;
            if (acc)  m_busy[rsv_addr] = 1;
            if (g >= 0) begin
                m_en   = 1;
                m_addr = int'(req_addr[g*4 +: 4]);
                m_din  = req_data[g*32 +: 32];
                m_ptr  = (g + 1) % 2;
            end else begin
                m_en = 0;
            end
        end
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; src1 = '0; src2 = '0;
        m_en = 0; m_addr = 0; m_din = '0; m_ptr = 0; last_g = -1;
        for (int r = 0; r < RF_NUM_REGS; r++) begin m_busy[r] = 0; bank[r] = '0; end
        held[0] = 0; held[1] = 0;
        @(posedge clk);
        @(negedge clk);

        // 1. Reset with both requesters valid
        rst = 1'b1; req_valid = 2'b11;
        for (int n = 0; n < 2; n++) begin
            #1;
            chk("t1_ready", req_ready, 2'b00);
            chk("t1_rf_en", rf_en, 1'b0);
            chk("t1_busy",  busy_vec, 16'h0);
            step();
        end

        // 2. Single write and readback
        rst = 1'b0; req_valid = 2'b01; req_addr[3:0] = 4'd1; req_data[31:0] = 32'h42568399;
        step();
        req_valid = 2'b00;
        #1;
        chk("t2_rf_en",   rf_en,   1'b1);
        chk("t2_rf_addr", rf_addr, 4'd1);
        chk("t2_rf_din",  rf_din,  32'h42568399);
        step();
        src1 = 4'd1;
        #1;
        chk("t2_readback", bank[src1], 32'h42568399);
        step();

        // 3. Contention from reset
        rst = 1'b1; req_valid = 2'b11;
        req_addr = {4'd3, 4'd2}; req_data = {32'h00022231, 32'h002711a8};
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("t3_rf_en", rf_en, 1'b1);
            step();
        end
        req_valid = 2'b00;
        step();

        // 4. RAW hazard on r5
        rsv_valid = 1'b1; rsv_addr = 4'd5;
        step();
        rsv_valid = 1'b0; src1 = 4'd5;
        #1;
        chk("t4_busy_set", src1_busy, 1'b1);
        step();
        req_valid = 2'b10; req_addr[7:4] = 4'd5; req_data[63:32] = 32'hcafe0005;
        step();
        req_valid = 2'b00;
        #1;
        chk("t4_rf_en",   rf_en,     1'b1);
        chk("t4_rf_addr", rf_addr,   4'd5);
        chk("t4_no_byp",  src1_busy, 1'b1);
        step();
        #1;
        chk("t4_cleared", src1_busy, 1'b0);
        step();

        // 5. Set/clear collision on r7
        req_valid = 2'b01; req_addr[3:0] = 4'd7; req_data[31:0] = 32'h00000777;
        step();
        req_valid = 2'b00; rsv_valid = 1'b1; rsv_addr = 4'd7;
        #1;
        chk("t5_rf_en",   rf_en,     1'b1);
        chk("t5_rf_addr", rf_addr,   4'd7);
        chk("t5_rsv_rdy", rsv_ready, 1'b1);
        step();
        rsv_valid = 1'b0;
        #1;
        chk("t5_busy7", busy_vec[7], 1'b1);
        step();

        // 6. WAW stall on r4
        rsv_valid = 1'b1; rsv_addr = 4'd4;
        step();
        req_valid = 2'b01; req_addr[3:0] = 4'd4; req_data[31:0] = 32'h00000444;
        #1;
        chk("t6_stall0", rsv_ready, 1'b0);
        step();
        req_valid = 2'b00;
        #1;
        chk("t6_stall1", rsv_ready, 1'b0);
        step();
        #1;
        chk("t6_release", rsv_ready, 1'b1);
        step();
        rsv_valid = 1'b0;
        #1;
        chk("t6_busy4", busy_vec[4], 1'b1);
        step();

        // 7. Reset the cycle after a transfer
        req_valid = 2'b01; req_addr[3:0] = 4'd9; req_data[31:0] = 32'h00000999;
        step();
        req_valid = 2'b00; rst = 1'b1;
        #1;
        chk("t7_pre_en", rf_en, 1'b1);
        step();
        rst = 1'b0; req_valid = 2'b11;
        #1;
        chk("t7_rf_en", rf_en,     1'b0);
        chk("t7_busy",  busy_vec,  16'h0);
        chk("t7_ptr",   req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();

        // Random traffic; a valid, unaccepted requester keeps its address/data
        held[0] = 0; held[1] = 0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 2; i++) begin
                bit nv;
                nv = ($urandom_range(0, 2) != 0);
                if (!(held[i] && nv)) begin
                    req_addr[i*4 +: 4]   = 4'($urandom_range(0, 7));
                    req_data[i*32 +: 32] = $urandom;
                end
                req_valid[i] = nv;
            end
            rsv_valid = ($urandom_range(0, 1) == 1);
            rsv_addr  = 4'($urandom_range(0, 7));
            src1      = 4'($urandom_range(0, 15));
            src2      = 4'($urandom_range(0, 15));
            step();
            for (int i = 0; i < 2; i++) held[i] = req_valid[i] && (last_g != i);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
